// File: rtl/encoder_dense_mac.sv
// encoder_dense_mac: streaming dense-layer multiply-accumulate.
// Each vector is a run of up to N_IN beats of (x_data * w_data). The bias is
// added on the first beat. The sum is arithmetically shifted right by SHIFT,
// saturated to signed 16 bits, and held until the consumer takes it.
// Optional feature: define ENCODER_DENSE_MAC_RELU_EN to clamp negative results to 0.
module encoder_dense_mac #(
   parameter int N_IN      = 16,
   parameter int SHIFT     = 10,
   parameter int ACC_WIDTH = 40
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] x_data,
   input  logic        [11:0] w_data,
   input  logic signed [27:0] bias_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_data,
   output logic               err
);

   localparam int                    CNT_W    = $clog2(N_IN);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(N_IN - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32'sd32767);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32'sd32768);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t                        r_state;
   logic [CNT_W-1:0]              r_cnt;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic signed [15:0]            r_out_data;
   logic                          r_out_valid;
   logic                          r_err;

   logic                          w_accept;
   logic                          w_at_last;
   logic                          w_end;
   logic signed [28:0]            w_x_ext;
   logic signed [28:0]            w_w_ext;
   logic signed [28:0]            w_prod;
   logic signed [ACC_WIDTH-1:0]   w_prod_ext;
   logic signed [ACC_WIDTH-1:0]   w_bias_ext;
   logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
   logic signed [ACC_WIDTH-1:0]   w_shifted;
   logic signed [15:0]            w_sat;
   logic signed [15:0]            w_result;

   // The block is ready only in ACCUM and never while reset is asserted.
   assign in_ready  = (r_state == ACCUM) & ~ap_rst;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign err       = r_err;

   assign w_accept  = in_valid & in_ready;
   assign w_at_last = (r_cnt == CNT_LAST);
   assign w_end     = w_accept & (w_at_last | in_last);

   // The weight is unsigned, so it is zero-extended before the signed multiply.
   // The product magnitude is below 2^27, so 29 bits hold it exactly.
   assign w_x_ext    = {{13{x_data[15]}}, x_data};
   assign w_w_ext    = {17'd0, w_data};
   assign w_prod     = w_x_ext * w_w_ext;
   assign w_prod_ext = {{(ACC_WIDTH-29){w_prod[28]}}, w_prod};
   assign w_bias_ext = {{(ACC_WIDTH-28){bias_data[27]}}, bias_data};
   assign w_acc_nxt  = (r_cnt == '0) ? (w_prod_ext + w_bias_ext) : (r_acc + w_prod_ext);
   assign w_shifted  = w_acc_nxt >>> SHIFT;

   // Saturate the scaled sum to the signed 16-bit output range, then apply the optional ReLU.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_sat = w_shifted[15:0];
      if (w_shifted > SAT_MAX)
         w_sat = 16'sh7FFF;
      else if (w_shifted < SAT_MIN)
         w_sat = 16'sh8000;
`ifdef ENCODER_DENSE_MAC_RELU_EN
      w_result = w_sat[15] ? 16'sd0 : w_sat;
`else
      w_result = w_sat;
`endif
   end

   // ACCUM/HOLD control, beat counter, accumulator, registered result and sticky error.
   always_ff @(posedge ap_clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (ap_rst) begin
         r_state     <= ACCUM;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  r_acc <= w_acc_nxt;
                  // in_last must appear exactly on the last counted beat.
                  if (in_last != w_at_last)
                     r_err <= 1'b1;
                  if (w_end) begin
                     r_cnt       <= '0;
                     r_out_data  <= w_result;
                     r_out_valid <= 1'b1;
                     r_state     <= HOLD;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ACCUM;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_dense_mac.sv
// Directed bench for encoder_dense_mac with N_IN=4 and SHIFT=10.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_encoder_dense_mac;

   logic               ap_clk    = 1'b0;
   logic               ap_rst    = 1'b1;
   logic               in_valid  = 1'b0;
   logic               in_ready;
   logic signed [15:0] x_data    = '0;
   logic        [11:0] w_data    = '0;
   logic signed [27:0] bias_data = '0;
   logic               in_last   = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [15:0] out_data;
   logic               err;

   int n_vec = 0;
   int n_bad = 0;

   encoder_dense_mac #(.N_IN(4), .SHIFT(10), .ACC_WIDTH(40)) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_data    (x_data),
      .w_data    (w_data),
      .bias_data (bias_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One accepted beat: present on a falling edge, accepted on the next rising edge.
   task automatic beat(input logic signed [15:0] x, input logic [11:0] w,
                       input logic signed [27:0] b, input logic last, input int gap);
      in_valid  = 1'b1;
      x_data    = x;
      w_data    = w;
      bias_data = b;
      in_last   = last;
      @(posedge ap_clk);
      @(negedge ap_clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) @(negedge ap_clk);
   endtask

   task automatic send_vec(input logic signed [15:0] x, input logic [11:0] w,
                           input logic signed [27:0] b, input int n,
                           input logic last_on_end, input int gap);
      for (int i = 0; i < n; i++)
         beat(x, w, b, last_on_end && (i == n - 1), (i < n - 1) ? gap : 0);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      out_ready = 1'b0;
      check("in_ready_after_consume", in_ready, 1);
      check("out_valid_after_consume", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [15:0] held;
      logic signed [31:0] exp_neg;

      // Reset state.
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_err", err, 0);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("in_ready_after_rst", in_ready, 1);

      // Four beats of 1024*1 with gaps: 4096 >>> 10 = 4, valid one cycle after beat 4.
      send_vec(16'sd1024, 12'd1, 28'sd0, 3, 1'b0, 2);
      check("basic_no_early_valid", out_valid, 0);
      beat(16'sd1024, 12'd1, 28'sd0, 1'b1, 0);
      check("basic_valid", out_valid, 1);
      check("basic_data", out_data, 4);
      check("basic_err", err, 0);
      consume();

      // Positive saturation: 4*32767*4095 = 536723460 -> 524144 -> 32767.
      send_vec(16'sd32767, 12'd4095, 28'sd0, 4, 1'b1, 0);
      check("sat_pos", out_data, 32767);
      consume();

      // Negative saturation: 4*-32768*4095 >>> 10 = -524160 -> -32768 (0 with ReLU).
`ifdef ENCODER_DENSE_MAC_RELU_EN
      exp_neg = 0;
`else
      exp_neg = -32768;
`endif
      send_vec(-16'sd32768, 12'd4095, 28'sd0, 4, 1'b1, 0);
      check("sat_neg", out_data, exp_neg);
      consume();

      // Small negative: 4*-2048 = -8192 -> -8 (0 with ReLU).
`ifdef ENCODER_DENSE_MAC_RELU_EN
      exp_neg = 0;
`else
      exp_neg = -8;
`endif
      send_vec(-16'sd1024, 12'd2, 28'sd0, 4, 1'b1, 0);
      check("neg_small", out_data, exp_neg);
      held = out_data;

      // Backpressure: hold 5 cycles with a beat offered that must not be taken.
      in_valid  = 1'b1;
      x_data    = 16'sd1024;
      w_data    = 12'd1;
      bias_data = 28'sd5000;
      for (int i = 0; i < 5; i++) begin
         @(negedge ap_clk);
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, held);
         check("hold_in_ready", in_ready, 0);
      end
      consume();
      in_valid = 1'b0;
      send_vec(16'sd1024, 12'd1, 28'sd0, 4, 1'b1, 0);
      check("after_hold_data", out_data, 4);
      check("after_hold_err", err, 0);
      consume();

      // Early in_last on beat 2: 1024 + 1024 + bias 1024 = 3072 -> 3, err set.
      send_vec(16'sd1024, 12'd1, 28'sd1024, 2, 1'b1, 0);
      check("early_last_valid", out_valid, 1);
      check("early_last_data", out_data, 3);
      check("early_last_err", err, 1);
      consume();
      send_vec(16'sd1024, 12'd1, 28'sd0, 4, 1'b1, 0);
      check("sticky_data", out_data, 4);
      check("sticky_err", err, 1);
      consume();

      // Reset after 2 beats discards the partial sum and clears err.
      send_vec(16'sd1024, 12'd1, 28'sd0, 2, 1'b0, 0);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      check("midrst_err", err, 0);
      check("midrst_valid", out_valid, 0);
      send_vec(16'sd1024, 12'd1, 28'sd0, 4, 1'b1, 0);
      check("midrst_data", out_data, 4);
      check("midrst_err_after", err, 0);
      consume();

      // Missing in_last on the last counted beat still ends the vector but sets err.
      send_vec(16'sd1024, 12'd1, 28'sd2048, 4, 1'b0, 0);
      check("no_last_valid", out_valid, 1);
      check("no_last_data", out_data, 6);
      check("no_last_err", err, 1);
      consume();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
